// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - redirect, instruction-memory and decode-side signals of the fetch unit
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_pc, inst_data
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_pc, inst_data
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, single-outstanding imem requester and 2-entry instruction buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

  state_t      state;
  state_t      state_next;
  logic        imem_req_q;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_data [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        push;
  logic        pop;
  logic        space;

  assign pop        = (count != 2'd0) && bus.inst_ready;
  assign push       = (state == WAIT) && bus.imem_rvalid && !bus.redirect;
  assign count_next = count + {1'b0, push} - {1'b0, pop};
  // A new request is only launched when its response is sure to find a free slot.
  assign space      = (count_next < 2'd2);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.redirect || space) state_next = REQ;
      REQ:   if (bus.imem_gnt) state_next = bus.redirect ? FLUSH : WAIT;
      WAIT: begin
        if (bus.imem_rvalid)   state_next = (bus.redirect || space) ? REQ : IDLE;
        else if (bus.redirect) state_next = FLUSH;
      end
      FLUSH: if (bus.imem_rvalid) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      imem_req_q <= 1'b0;
      fetch_pc   <= RESET_ADDR;
      req_pc     <= RESET_ADDR;
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]   <= 32'd0;
        fifo_data[i] <= 32'd0;
      end
    end else begin
      state      <= state_next;
      imem_req_q <= (state_next == REQ);
      count      <= count_next;
      if (state == REQ && bus.imem_gnt) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        fifo_pc[wr_ptr]   <= req_pc;
        fifo_data[wr_ptr] <= bus.imem_rdata;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // Redirect overrides the sequential update and empties the buffer.
      if (bus.redirect) begin
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        count    <= 2'd0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
      end
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = (count != 2'd0);
  assign bus.inst_pc    = fifo_pc[rd_ptr];
  assign bus.inst_data  = fifo_data[rd_ptr];

endmodule
